// File: rtl/nlin_lut_interp_unit_pkg.sv
// Shared types and defaults for the nonlinear activation unit: mode encoding,
// the per-lane pipeline word and the fixed-point constants.
package nlin_lut_interp_unit_pkg;

   localparam int C_ARITH_WORD_LEN = 16;
   localparam int DEF_FRAC_WDT     = 8;
   localparam int DEF_LIN_END      = 32;
   localparam int DEF_INTERP_WDT   = 3;
   localparam logic [C_ARITH_WORD_LEN-1:0] ONE = C_ARITH_WORD_LEN'(1 << DEF_FRAC_WDT);

   typedef enum logic [1:0] {
      NLIN_BYPASS = 2'd0,
      NLIN_TANH   = 2'd1,
      NLIN_SIGM   = 2'd2
   } nlin_mode_t;

   typedef struct packed {
      logic [1:0]                  data_type;
      logic                        data_last;
      logic                        data_val;
      logic [C_ARITH_WORD_LEN-1:0] data_word;
   } pipe_data_t;

endpackage

// File: rtl/nlin_lut_interp_unit_lane.sv
// One activation lane: four-stage tanh / sigmoid / bypass evaluation with a
// private interpolation table (lo = entry i, hi = entry i+1).
module nlin_interp_lane
   import nlin_lut_interp_unit_pkg::*;
#(
   parameter int WORD_WDT     = C_ARITH_WORD_LEN,
   parameter int FRAC_WDT     = DEF_FRAC_WDT,
   parameter int LUT_ADDR_WDT = 6,
   parameter int INTERP_WDT   = DEF_INTERP_WDT,
   parameter int LIN_END      = DEF_LIN_END
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clk_en,
   input  pipe_data_t              op,
   input  logic [1:0]              op_mode,
   input  logic                    lut_wr_en,
   input  logic [LUT_ADDR_WDT-1:0] lut_wr_addr,
   input  logic [WORD_WDT-1:0]     lut_wr_data,
   output pipe_data_t              res
);
   localparam int LUT_DEPTH = 2**LUT_ADDR_WDT;
   localparam int OFF_WDT   = LUT_ADDR_WDT + INTERP_WDT;
   localparam int SAT_START = LIN_END + 2**OFF_WDT;
   localparam int PROD_WDT  = WORD_WDT + INTERP_WDT + 1;
   localparam logic [WORD_WDT-1:0] ONE_W    = WORD_WDT'(1 << FRAC_WDT);
   localparam logic [WORD_WDT-1:0] MAX_POS  = {1'b0, {(WORD_WDT-1){1'b1}}};
   localparam logic [WORD_WDT-1:0] MOST_NEG = {1'b1, {(WORD_WDT-1){1'b0}}};

   typedef struct packed {
      logic [1:0] mode;
      logic [1:0] data_type;
      logic       data_last;
      logic       data_val;
   } side_t;

   logic [WORD_WDT-1:0] lo_mem [LUT_DEPTH];
   logic [WORD_WDT-1:0] hi_mem [LUT_DEPTH];

   side_t                   s1_side, s2_side, s3_side;
   logic [WORD_WDT-1:0]     s1_x, s2_x, s3_x, s1_a, s2_a, s2_lo, s2_hi, s3_t;
   logic                    s1_sgn, s2_sgn, s3_sgn, s1_lin, s1_sat, s2_lin, s2_sat;
   logic [LUT_ADDR_WDT-1:0] s1_idx;
   logic [INTERP_WDT-1:0]   s1_f, s2_f;

   logic [WORD_WDT-1:0]        x_half, a_c, t_c, y_c;
   logic [OFF_WDT-1:0]         off_c;
   logic                       lin_c, sat_c, lut_rd;
   logic signed [WORD_WDT:0]   diff_c;
   logic signed [PROD_WDT-1:0] prod_c;

   // Table writes ignore reset and clk_en; hi[last] is never stored, it reads as ONE.
   always_ff @(posedge clk) begin
      if (lut_wr_en) begin
         lo_mem[lut_wr_addr] <= lut_wr_data;
         if (lut_wr_addr != '0)
            hi_mem[lut_wr_addr - LUT_ADDR_WDT'(1)] <= lut_wr_data;
      end
   end

   always_comb begin
      x_half = (op_mode == NLIN_SIGM) ? {op.data_word[WORD_WDT-1], op.data_word[WORD_WDT-1:1]}
                                      : op.data_word;
      if (x_half == MOST_NEG)      a_c = MAX_POS;
      else if (x_half[WORD_WDT-1]) a_c = ~x_half + WORD_WDT'(1);
      else                         a_c = x_half;
      lin_c = (a_c <= WORD_WDT'(LIN_END));
      sat_c = (a_c >= WORD_WDT'(SAT_START));
      off_c = OFF_WDT'(a_c - WORD_WDT'(LIN_END));
   end

   assign lut_rd = s1_side.data_val && !s1_lin && !s1_sat;

   always_comb begin
      diff_c = $signed({1'b0, s2_hi}) - $signed({1'b0, s2_lo});
      prod_c = $signed({{(PROD_WDT-WORD_WDT-1){diff_c[WORD_WDT]}}, diff_c})
             * $signed({{(PROD_WDT-INTERP_WDT){1'b0}}, s2_f});
      if (s2_lin)      t_c = s2_a;
      else if (s2_sat) t_c = ONE_W;
      else             t_c = s2_lo + WORD_WDT'(prod_c >>> INTERP_WDT);
   end

   always_comb begin
      case (s3_side.mode)
         NLIN_TANH: y_c = s3_sgn ? -s3_t : s3_t;
         NLIN_SIGM: y_c = s3_sgn ? ((ONE_W - s3_t) >> 1) : ((ONE_W + s3_t) >> 1);
         default:   y_c = s3_x;
      endcase
   end

   // Table reads are read-first against a same-edge write of the same entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_side <= '0; s1_x <= '0; s1_a <= '0; s1_sgn <= 1'b0;
         s1_lin  <= 1'b0; s1_sat <= 1'b0; s1_idx <= '0; s1_f <= '0;
         s2_side <= '0; s2_x <= '0; s2_a <= '0; s2_sgn <= 1'b0;
         s2_lin  <= 1'b0; s2_sat <= 1'b0; s2_lo <= '0; s2_hi <= '0; s2_f <= '0;
         s3_side <= '0; s3_x <= '0; s3_sgn <= 1'b0; s3_t <= '0;
         res     <= '0;
      end else if (clk_en) begin
         s1_side <= '{mode: op_mode, data_type: op.data_type,
                      data_last: op.data_last, data_val: op.data_val};
         s1_x    <= op.data_word;
         s1_a    <= a_c;
         s1_sgn  <= op.data_word[WORD_WDT-1];
         s1_lin  <= lin_c;
         s1_sat  <= sat_c;
         s1_idx  <= off_c[INTERP_WDT +: LUT_ADDR_WDT];
         s1_f    <= off_c[INTERP_WDT-1:0];

         s2_side <= s1_side; s2_x <= s1_x; s2_a <= s1_a; s2_sgn <= s1_sgn;
         s2_lin  <= s1_lin;  s2_sat <= s1_sat; s2_f <= s1_f;
         if (lut_rd) begin
            s2_lo <= lo_mem[s1_idx];
            s2_hi <= (s1_idx == '1) ? ONE_W : hi_mem[s1_idx];
         end

         s3_side <= s2_side; s3_x <= s2_x; s3_sgn <= s2_sgn; s3_t <= t_c;

         res <= '{data_type: s3_side.data_type, data_last: s3_side.data_last,
                  data_val: s3_side.data_val,
                  data_word: s3_side.data_val ? y_c : {WORD_WDT{1'b0}}};
      end
   end

   lin_sat_excl: assert property (@(posedge clk) disable iff (!rst_n) !(s1_lin && s1_sat));
   mode3_seen: assert property (@(posedge clk) disable iff (!rst_n)
      (clk_en && op.data_val) |-> (op_mode != 2'd3))
      else $warning("nlin_interp_lane: op_mode 3 handled as bypass");

endmodule

// File: rtl/nlin_lut_interp_unit.sv
// Multi-lane tanh / sigmoid / bypass unit with linearly interpolated LUT region;
// one broadcast LUT write port keeps every lane's table copy identical.
module nlin_lut_interp_unit
   import nlin_lut_interp_unit_pkg::*;
#(
   parameter int LANE_CNT     = 4,
   parameter int WORD_WDT     = C_ARITH_WORD_LEN,
   parameter int FRAC_WDT     = DEF_FRAC_WDT,
   parameter int LUT_ADDR_WDT = 6,
   parameter int INTERP_WDT   = DEF_INTERP_WDT,
   parameter int LIN_END      = DEF_LIN_END
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clk_en,
   input  pipe_data_t [LANE_CNT-1:0]    op,
   input  logic [1:0]                   op_mode,
   input  logic                         lut_wr_en,
   input  logic [LUT_ADDR_WDT-1:0]      lut_wr_addr,
   input  logic [WORD_WDT-1:0]          lut_wr_data,
   output pipe_data_t [LANE_CNT-1:0]    res
);
   // data_val qualifies each lane word; there is no ready: the unit never
   // back-pressures, the caller stalls all four stages together via clk_en.
   for (genvar i = 0; i < LANE_CNT; i++) begin : g_lane
      nlin_interp_lane #(
         .WORD_WDT     (WORD_WDT),
         .FRAC_WDT     (FRAC_WDT),
         .LUT_ADDR_WDT (LUT_ADDR_WDT),
         .INTERP_WDT   (INTERP_WDT),
         .LIN_END      (LIN_END)
      ) u_lane (
         .clk         (clk),
         .rst_n       (rst_n),
         .clk_en      (clk_en),
         .op          (op[i]),
         .op_mode     (op_mode),
         .lut_wr_en   (lut_wr_en),
         .lut_wr_addr (lut_wr_addr),
         .lut_wr_data (lut_wr_data),
         .res         (res[i])
      );
   end

endmodule
